// File: rtl/multicycle_control_fsm.sv
// Moore control unit for the multicycle O9 CPU: walks fetch/decode/execute
// states and decodes every datapath strobe purely from the state register.
module multicycle_control_fsm #(
  parameter int          COUNT_W = 32,
  parameter logic [5:0]  OP_R    = 6'b000000,
  parameter logic [5:0]  OP_LW   = 6'b100011,
  parameter logic [5:0]  OP_SW   = 6'b101011,
  parameter logic [5:0]  OP_BEQ  = 6'b000100,
  parameter logic [5:0]  OP_ADDI = 6'b001000,
  parameter logic [5:0]  OP_J    = 6'b000010,
  parameter logic [5:0]  OP_HALT = 6'b111111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opCode,
  output logic               PCWriteCond,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcB,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [3:0]         state,
  output logic               halted,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH0 = 4'd0;
  localparam logic [3:0] S_FETCH1 = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_REX    = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_IEX    = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BEQ    = 4'd10;
  localparam logic [3:0] S_JMP    = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;
  localparam logic [3:0] S_ERR    = 4'd13;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_ALUR = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  logic [3:0] next_state;
  logic       retire;

  // opCode has no handshake: the datapath holds IR stable from FETCH1 onward,
  // and only the DECODE-state edge consumes it.
  function automatic logic [3:0] dispatch(input logic [5:0] op);
    logic [3:0] nxt;
    nxt = S_ERR;
    if (op == OP_LW)        nxt = S_MEMRD;
    else if (op == OP_SW)   nxt = S_MEMWR;
    else if (op == OP_R)    nxt = S_REX;
    else if (op == OP_ADDI) nxt = S_IEX;
    else if (op == OP_BEQ)  nxt = S_BEQ;
    else if (op == OP_J)    nxt = S_JMP;
    else if (op == OP_HALT) nxt = S_HALT;
    return nxt;
  endfunction

  always_comb begin
    next_state = S_FETCH0;
    case (state)
      S_FETCH0: next_state = S_FETCH1;
      S_FETCH1: next_state = S_DECODE;
      S_DECODE: next_state = dispatch(opCode);
      S_MEMRD:  next_state = S_MEMWB;
      S_MEMWB:  next_state = S_FETCH0;
      S_MEMWR:  next_state = S_FETCH0;
      S_REX:    next_state = S_RWB;
      S_RWB:    next_state = S_FETCH0;
      S_IEX:    next_state = S_IWB;
      S_IWB:    next_state = S_FETCH0;
      S_BEQ:    next_state = S_FETCH0;
      S_JMP:    next_state = S_FETCH0;
      S_HALT:   next_state = S_HALT;
      S_ERR:    next_state = S_ERR;
      default:  next_state = S_FETCH0;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BEQ, S_JMP: retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + COUNT_W'(1);
    end
  end

  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALU_ADD;
    ALUSrcB     = SRCB_B;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH0: begin
        IorD    = 1'b0;
        MemRead = 1'b1;
      end
      S_FETCH1: begin
        IRWrite  = 1'b1;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_ONE;
        ALUOp    = ALU_ADD;
        PCSource = PCSRC_ALU;
        PCWrite  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegDst   = 1'b0;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        ALUOp    = ALU_ADD;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_B;
        ALUOp   = ALU_FUNCT;
      end
      S_RWB: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_B;
        ALUOp    = ALU_FUNCT;
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = 1'b0;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
      end
      S_IWB: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        ALUOp    = ALU_ADD;
        RegDst   = 1'b0;
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUR;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_HALT:  halted  = 1'b1;
      S_ERR:   illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instruction table, sink-state and
// async-reset sequences, counter wrap, then random programs against a path model.
module tb_multicycle_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic        clk;
  logic        reset;
  logic [5:0]  opCode;
  logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic        ALUSrcA, RegWrite, RegDst, halted, illegal;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        s_pcwc, s_pcw, s_iord, s_mr, s_mw, s_m2r, s_irw, s_asa, s_rw, s_rd;
  logic        s_halted, s_illegal;
  logic [1:0]  s_pcs, s_aop, s_asb;
  logic [3:0]  s_state;
  logic [2:0]  s_count;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_count;
  logic [3:0]  exp_q[$];

  typedef struct {
    logic [5:0] op;
    int         len;
    logic [3:0] path [5];
  } vec_t;
  vec_t vecs [7];

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opCode(opCode),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .state(state), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  // Narrow-counter twin: shares all inputs so its count wraps within a short run.
  multicycle_control_fsm #(.COUNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .opCode(opCode),
    .PCWriteCond(s_pcwc), .PCWrite(s_pcw), .IorD(s_iord), .MemRead(s_mr),
    .MemWrite(s_mw), .MemtoReg(s_m2r), .IRWrite(s_irw), .PCSource(s_pcs),
    .ALUOp(s_aop), .ALUSrcB(s_asb), .ALUSrcA(s_asa), .RegWrite(s_rw),
    .RegDst(s_rd), .state(s_state), .halted(s_halted), .illegal(s_illegal),
    .instr_count(s_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] act_ctrl();
    return {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
            PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, halted, illegal};
  endfunction

  // Strobes expressed as "which states assert this signal".
  function automatic logic [17:0] exp_ctrl(input int s);
    logic pcwc, pcw, iord, mr, mw, m2r, irw, asa, rw, rd, h, il;
    logic [1:0] pcs, aop, asb;
    pcwc = (s == 10);
    pcw  = (s == 1) || (s == 11);
    iord = (s == 3) || (s == 5);
    mr   = (s == 0) || (s == 3);
    mw   = (s == 5);
    m2r  = (s == 4);
    irw  = (s == 1);
    pcs  = (s == 10) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00;
    aop  = (s == 6 || s == 7) ? 2'b10 : (s == 10) ? 2'b01 : 2'b00;
    asb  = (s == 1) ? 2'b01 : (s inside {2, 3, 5, 8, 9}) ? 2'b10 : 2'b00;
    asa  = s inside {3, 5, 6, 7, 8, 9, 10};
    rw   = s inside {4, 7, 9};
    rd   = (s == 7);
    h    = (s == 12);
    il   = (s == 13);
    return {pcwc, pcw, iord, mr, mw, m2r, irw, pcs, aop, asb, asa, rw, rd, h, il};
  endfunction

  task automatic check_cycle(input logic [3:0] s);
    check($sformatf("state exp=%0d", s), 32'(state), 32'(s));
    check($sformatf("ctrl st=%0d", s), 32'(act_ctrl()), 32'(exp_ctrl(int'(s))));
    check("instr_count", instr_count, exp_count);
    check("instr_count_w3", 32'(s_count), exp_count % 8);
    check("memwrite_regwrite_excl", 32'(MemWrite & RegWrite), 32'd0);
    check("pcwrite_pcwritecond_excl", 32'(PCWrite & PCWriteCond), 32'd0);
  endtask

  // ---------------- reference model ----------------
  // Whole-instruction view: the state walk an opcode produces from fetch.
  function automatic void push_path(input logic [5:0] op, input int hold);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    case (op)
      OP_LW:   begin exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
      OP_SW:   exp_q.push_back(4'd5);
      OP_R:    begin exp_q.push_back(4'd6); exp_q.push_back(4'd7); end
      OP_ADDI: begin exp_q.push_back(4'd8); exp_q.push_back(4'd9); end
      OP_BEQ:  exp_q.push_back(4'd10);
      OP_J:    exp_q.push_back(4'd11);
      OP_HALT: for (int i = 0; i < hold; i++) exp_q.push_back(4'd12);
      default: for (int i = 0; i < hold; i++) exp_q.push_back(4'd13);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Runs the queued walk; entered just before the FETCH0 sample point.
  task automatic run_queue(input logic [5:0] op);
    logic [3:0] s;
    logic [3:0] last;
    last   = 4'd0;
    opCode = op;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      @(negedge clk);
      check_cycle(s);
      last = s;
    end
    if (last != 4'd12 && last != 4'd13) exp_count = exp_count + 32'd1;
  endtask

  // Reset dropped mid-cycle; state and counter must clear before any edge.
  task automatic async_reset_check();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_count", instr_count, 32'd0);
    check("async_rst_memread", 32'(MemRead), 32'd1);
    check("async_rst_ctrl", 32'(act_ctrl()), 32'(exp_ctrl(0)));
    check("async_rst_count_w3", 32'(s_count), 32'd0);
    exp_count = 32'd0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [5:0] op;
    logic [5:0] legal [7];
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 32'd0;
    reset     = 1'b0;
    opCode    = 6'd0;

    vecs[0] = '{op: OP_LW,   len: 5, path: '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}};
    vecs[1] = '{op: OP_SW,   len: 4, path: '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0}};
    vecs[2] = '{op: OP_R,    len: 5, path: '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7}};
    vecs[3] = '{op: OP_ADDI, len: 5, path: '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9}};
    vecs[4] = '{op: OP_BEQ,  len: 4, path: '{4'd0, 4'd1, 4'd2, 4'd10, 4'd0}};
    vecs[5] = '{op: OP_J,    len: 4, path: '{4'd0, 4'd1, 4'd2, 4'd11, 4'd0}};
    vecs[6] = '{op: OP_LW,   len: 5, path: '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}};
    legal   = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT};

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_count", instr_count, 32'd0);
    check("reset_ctrl", 32'(act_ctrl()), 32'(exp_ctrl(0)));
    reset = 1'b1;

    // Directed instruction table.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vecs[v].len; i++) exp_q.push_back(vecs[v].path[i]);
      run_queue(vecs[v].op);
    end

    // Illegal opcode: ERR on cycle 4, held 20 cycles with counter frozen.
    exp_q = {4'd0, 4'd1, 4'd2};
    for (int i = 0; i < 20; i++) exp_q.push_back(4'd13);
    run_queue(6'b010101);
    async_reset_check();

    // HALT then asynchronous reset mid-cycle.
    exp_q = {4'd0, 4'd1, 4'd2, 4'd12, 4'd12, 4'd12};
    run_queue(OP_HALT);
    async_reset_check();

    // Eight jumps wrap the 3-bit counter back to zero.
    for (int i = 0; i < 8; i++) begin
      exp_q = {4'd0, 4'd1, 4'd2, 4'd11};
      run_queue(OP_J);
    end
    @(posedge clk);
    #1;
    check("wrap_count_w3", 32'(s_count), 32'd0);
    check("wrap_count_w32", instr_count, 32'd8);

    // Random programs against the path model.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 8) op = legal[$urandom_range(0, 5)];
      else if ($urandom_range(0, 1) == 1) op = OP_HALT;
      else op = 6'($urandom_range(0, 63));
      push_path(op, int'($urandom_range(1, 4)));
      run_queue(op);
      if (state == 4'd12 || state == 4'd13 || exp_q.size() != 0 ||
          !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}))
        async_reset_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore control unit for the multicycle O9 CPU; sits directly upstream of the datapath.
- Consumes the datapath's opCode and drives every datapath control strobe: PC write enables, memory/IR strobes, mux selects, ALU op class and register-file write.
- Also provides debug/status outputs: current state, halted, illegal-opcode flag and a retired-instruction counter.

Parameters:
- COUNT_W, 32, width of instr_count.
- OP_R, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load word.
- OP_SW, 6'b101011, store word.
- OP_BEQ, 6'b000100, branch on equal.
- OP_ADDI, 6'b001000, add immediate.
- OP_J, 6'b000010, jump.
- OP_HALT, 6'b111111, stop the machine.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- opCode  in  6  IR[31:26] from the datapath.
- PCWriteCond  out  1  PC write if ALU zero.
- PCWrite  out  1  unconditional PC write.
- IorD  out  1  0=PC, 1=ALU result as memory address.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write enable.
- MemtoReg  out  1  1=memory data to register file.
- IRWrite  out  1  load the IR.
- PCSource  out  2  00=ALU bus, 01=ALU register, 10=jump target.
- ALUOp  out  2  00=add, 01=sub, 10=funct-decoded; the datapath ALUOp port is 2 bits.
- ALUSrcB  out  2  00=B, 01=const 1, 10=signext imm, 11=shifted imm.
- ALUSrcA  out  1  0=PC, 1=A.
- RegWrite  out  1  register-file write.
- RegDst  out  1  0=rt, 1=rd.
- state  out  4  current state encoding.
- halted  out  1  high in HALT.
- illegal  out  1  high in ERR.
- instr_count  out  COUNT_W  retired instructions.

Behaviour:
- State register encodings: FETCH0=0, FETCH1=1, DECODE=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, IEX=8, IWB=9, BEQ=10, JMP=11, HALT=12, ERR=13.
- Any other state value goes to FETCH0.
- Outputs are pure decode of the state register (Moore); no output depends on opCode. Every signal not listed for a state is 0.
- Async reset (reset==0) forces state=FETCH0 and instr_count=0 immediately, including mid-instruction. Outputs then equal the FETCH0 decode: MemRead=1, all other strobes/selects 0, halted=0, illegal=0.
- Memory is synchronous: q is valid the cycle after the address is presented.

State actions and transitions:
- FETCH0: IorD=0, MemRead=1. Next: FETCH1.
- FETCH1: IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1, so PC<=PC+1 (word addressing). Next: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00; the ALU register captures the branch target PC+1+imm. Next by opCode:
  - LW -> MEMRD; SW -> MEMWR; R -> REX; ADDI -> IEX; BEQ -> BEQ; J -> JMP; HALT -> HALT.
  - Any other opcode -> ERR.
- MEMRD: IorD=1, MemRead=1, ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMWB.
- MEMWB: MemtoReg=1, RegDst=0, RegWrite=1. Next: FETCH0.
- MEMWR: IorD=1, MemWrite=1, ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: FETCH0.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: RWB.
- RWB: same selects as REX, plus RegDst=1, RegWrite=1, MemtoReg=0. Next: FETCH0.
- IEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: IWB.
- IWB: same selects as IEX, plus RegDst=0, RegWrite=1. Next: FETCH0.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH0.
- JMP: PCWrite=1, PCSource=10. Next: FETCH0.
- HALT: halted=1, MemRead=0, no writes. Self-loop until reset.
- ERR: illegal=1, no writes. Self-loop until reset.

Latency:
- LW 5 cycles; SW 4; R-type 5; ADDI 5; BEQ 4; J 4.
- HALT and ERR are entered on cycle 4.

instr_count:
- Increments by 1 on the clock edge leaving MEMWB, MEMWR, RWB, IWB, BEQ or JMP.
- Wraps modulo 2^COUNT_W.
- Frozen in HALT and ERR.

Exclusivity:
- MemWrite and RegWrite are never both 1.
- PCWrite and PCWriteCond are never both 1.
- IRWrite is 1 only in FETCH1.

Test Plan:
- Release reset with opCode=6'b100011 -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_count=1.
- opCode=6'b101011 -> states 0,1,2,5,0; MemWrite=1 with IorD=1 in state 5 only; RegWrite stays 0.
- opCode=6'b000100 -> state 10 drives PCWriteCond=1, ALUOp=01, PCSource=01; PCWrite=0 throughout state 10.
- opCode=6'b010101 (illegal) -> ERR (13) on cycle 4; illegal=1 held for 20 cycles; all write strobes 0; instr_count unchanged.
- opCode=6'b111111 -> HALT (12) with halted=1. Then assert reset=0 asynchronously mid-cycle -> state=0 and instr_count=0 before the next clk edge; MemRead=1.
- Preload instr_count to all-ones by forcing it, then run one J -> instr_count wraps to 0; PCSource=10 and PCWrite=1 in state 11.
